parallel_in_serial_out: RTL and testbench
=========================================

Name: parallel_in_serial_out

Overview:
- Transmit-side serializer. Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock on a single serial line.
- Pairs with the team's serial shift-register receive chain at the other end of the serial link.
- Supports back-to-back words with no idle gap between them.

Parameters:
- WIDTH, 8: word width in bits; legal range 2..32.
- MSB_FIRST, 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.
- IDLE_LEVEL, 0: value driven on dout whenever dout_valid=0.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  reset, synchronous, active-high.
- din  input  WIDTH  parallel word to transmit.
- din_valid  input  1  din holds a word to send.
- din_ready  output  1  block accepts din on this cycle.
- dout  output  1  serial data bit, registered.
- dout_valid  output  1  dout carries a data (or parity) bit, registered.
- dout_last  output  1  current dout bit is the final bit of the frame, registered.
- busy  output  1  a frame is in progress, registered.

Behaviour:
- Reset (sampled on clk edge while reset=1):
  - state=IDLE, shift register cleared, bit counter=0.
  - dout=IDLE_LEVEL, dout_valid=0, dout_last=0, busy=0.
  - din_ready forced 0 while reset=1; din_valid is ignored.
- Reset asserted mid-frame abandons the word with no further bits. Output returns to the idle values on the next edge.
- Handshake:
  - A transfer happens on any edge where din_valid=1 and din_ready=1.
  - din is captured into the shift register on that edge.
  - din_ready is combinational: 1 in IDLE, or in SHIFT on the final frame cycle (counter=WIDTH-1, or the PARITY cycle when parity is enabled). 0 otherwise.
  - din changes while din_ready=0 have no effect.
- Latency: the word accepted at edge N drives its first bit on dout immediately after edge N (visible during cycle N+1).
- FSM states:
  - IDLE: on transfer -> SHIFT, counter=0, dout=first bit, dout_valid=1, busy=1.
  - SHIFT: each edge, shift register shifts one position toward the output end and the counter increments.
  - At counter=WIDTH-1, the next state is:
    - PARITY, if the parity feature is enabled;
    - otherwise SHIFT with a new word (counter=0), if a transfer occurs;
    - otherwise IDLE.
  - PARITY (feature only): dout=parity bit for 1 cycle, then SHIFT if a transfer occurs, else IDLE.
- dout_last=1 exactly on the final bit of each frame: data bit WIDTH-1, or the parity bit.
- Frame length: WIDTH cycles, or WIDTH+1 with parity. dout_valid stays high continuously across back-to-back frames.
- Counter width: $clog2(WIDTH). The counter never wraps within a frame; it is reloaded to 0 on each new word.
- Returning to IDLE: dout=IDLE_LEVEL, dout_valid=0, busy=0 on the edge after the last bit.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined: one extra even-parity bit (XOR of all WIDTH captured data bits) is appended after the data bits, in the PARITY state. dout_last moves to the parity bit, and din_ready asserts on the PARITY cycle instead of data bit WIDTH-1.
- Undefined: no PARITY state, no parity logic; frames are exactly WIDTH bits.

Decomposition:
- Shared package piso_pkg holds:
  - state enum (IDLE, SHIFT, PARITY);
  - localparam function for the counter width;
  - default WIDTH constant, shared with the receive side.
- No sub-module: the shift register, counter and FSM are small enough to stay in one module.

Test Plan:
- WIDTH=8, MSB_FIRST=1: send din=0xA5 from IDLE -> dout over 8 cycles = 1,0,1,0,0,1,0,1. dout_valid high 8 cycles, dout_last on cycle 8 only, then dout=0, busy=0.
- MSB_FIRST=0: send 0xA5 -> dout = 1,0,1,0,0,1,0,1 (LSB first; this pattern is a palindrome). Then send 0x01 -> 1,0,0,0,0,0,0,0.
- Back-to-back: 0xA5 then 0x3C, with din_valid held high -> din_ready high only in IDLE and on bit 8. dout_valid high 16 consecutive cycles; second frame = 0,0,1,1,1,1,0,0.
- Backpressure: din_valid=1 with din=0xFF for all of frame 1 -> din_ready=0 until bit 8. 0xFF is accepted exactly once per frame.
- Reset on bit 4 of 0xA5 -> the next cycle dout=IDLE_LEVEL, dout_valid=0, busy=0. A new 0x3C after reset is sent cleanly from bit 0.
- PISO_PARITY_EN defined:
  - 0xA5 -> 9 bits, last = 0, dout_last on bit 9.
  - 0x07 -> parity bit = 1.
  - din_ready is asserted on the parity cycle.

Source files
------------

// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared types and constants for the serial link transmit/receive pair
//
// Contents:
//   piso_state_t       : serializer FSM states (IDLE, SHIFT, PARITY)
//   PISO_DEFAULT_WIDTH : default word width, shared with the receive side
//   piso_cnt_width()   : bit-counter width for a given word width
package piso_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } piso_state_t;

    localparam int PISO_DEFAULT_WIDTH = 8;

    // Counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice;
    // clamp to 1 so a degenerate width never yields a zero-width vector.
    function automatic int piso_cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/parallel_in_serial_out.sv
// rtl/parallel_in_serial_out.sv - transmit-side serializer, one bit per clock
//
// Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out on
// a single registered serial line. Back-to-back words are sent with no gap.
//
// Optional feature: define PISO_PARITY_EN to append an even-parity bit
// (XOR of the captured data bits) after the data bits of every frame.
//
// Parameters:
//   WIDTH      : word width in bits (2..32)
//   MSB_FIRST  : 1 sends bit WIDTH-1 first, 0 sends bit 0 first
//   IDLE_LEVEL : level driven on dout while dout_valid=0
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   din        in   parallel word to transmit
//   din_valid  in   din holds a word to send
//   din_ready  out  word accepted on this cycle when din_valid=1 (combinational)
//   dout       out  serial data bit (registered)
//   dout_valid out  dout carries a data/parity bit (registered)
//   dout_last  out  dout is the final bit of the frame (registered)
//   busy       out  a frame is in progress (registered)
module parallel_in_serial_out
    import piso_pkg::*;
#(
    parameter int   WIDTH      = PISO_DEFAULT_WIDTH,
    parameter int   MSB_FIRST  = 1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             dout_last,
    output logic             busy
);

    localparam int             CW       = piso_cnt_width(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  CNT_PEN  = CW'(WIDTH - 2);

    piso_state_t      state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;

`ifdef PISO_PARITY_EN
    logic             par_q;
`endif

    logic             last_data;
    logic             do_load;
    logic             load_bit;
    logic [WIDTH-1:0] load_sh;
    logic             next_bit;
    logic [WIDTH-1:0] next_sh;

    // The first bit of a new word goes straight to dout, so the shift register
    // is loaded already advanced by one position; it then always holds the
    // bits still waiting to be sent, aligned to the output end.
    always_comb begin
        last_data = (state == SHIFT) && (cnt == CNT_LAST);

`ifdef PISO_PARITY_EN
        din_ready = !reset && ((state == IDLE) || (state == PARITY));
`else
        din_ready = !reset && ((state == IDLE) || last_data);
`endif
        do_load = din_valid && din_ready;

        if (MSB_FIRST != 0) begin
            load_bit = din[WIDTH-1];
            load_sh  = {din[WIDTH-2:0], 1'b0};
            next_bit = shreg[WIDTH-1];
            next_sh  = {shreg[WIDTH-2:0], 1'b0};
        end else begin
            load_bit = din[0];
            load_sh  = {1'b0, din[WIDTH-1:1]};
            next_bit = shreg[0];
            next_sh  = {1'b0, shreg[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            dout       <= IDLE_LEVEL;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            busy       <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else if (do_load) begin
            // New word: reachable from IDLE or from the final cycle of a frame.
            state      <= SHIFT;
            shreg      <= load_sh;
            cnt        <= '0;
            dout       <= load_bit;
            dout_valid <= 1'b1;
            dout_last  <= 1'b0;
            busy       <= 1'b1;
`ifdef PISO_PARITY_EN
            par_q      <= ^din;
`endif
        end else begin
            case (state)
                IDLE: begin
                end
                SHIFT: begin
                    if (!last_data) begin
                        shreg <= next_sh;
                        cnt   <= cnt + CW'(1);
                        dout  <= next_bit;
`ifdef PISO_PARITY_EN
                        dout_last <= 1'b0;
`else
                        dout_last <= (cnt == CNT_PEN);
`endif
                    end else begin
`ifdef PISO_PARITY_EN
                        state     <= PARITY;
                        dout      <= par_q;
                        dout_last <= 1'b1;
`else
                        state      <= IDLE;
                        dout       <= IDLE_LEVEL;
                        dout_valid <= 1'b0;
                        dout_last  <= 1'b0;
                        busy       <= 1'b0;
`endif
                    end
                end
                default: begin
                    // PARITY without a following word, or an illegal encoding.
                    state      <= IDLE;
                    dout       <= IDLE_LEVEL;
                    dout_valid <= 1'b0;
                    dout_last  <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parallel_in_serial_out.sv
// tb/tb_parallel_in_serial_out.sv - self-checking bench for parallel_in_serial_out
module tb_parallel_in_serial_out;

    localparam int W = 8;
`ifdef PISO_PARITY_EN
    localparam int FLEN = W + 1;
`else
    localparam int FLEN = W;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] din, din_l;
    logic         din_valid, din_valid_l;
    logic         din_ready, din_ready_l;
    logic         dout, dout_l;
    logic         dout_valid, dout_valid_l;
    logic         dout_last, dout_last_l;
    logic         busy, busy_l;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    parallel_in_serial_out #(.WIDTH(W), .MSB_FIRST(1), .IDLE_LEVEL(1'b0)) u_msb (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .dout(dout), .dout_valid(dout_valid), .dout_last(dout_last), .busy(busy)
    );

    parallel_in_serial_out #(.WIDTH(W), .MSB_FIRST(0), .IDLE_LEVEL(1'b1)) u_lsb (
        .clk(clk), .reset(reset), .din(din_l), .din_valid(din_valid_l), .din_ready(din_ready_l),
        .dout(dout_l), .dout_valid(dout_valid_l), .dout_last(dout_last_l), .busy(busy_l)
    );

    // Bit i of a frame: data bits in the chosen order, then the even parity bit.
    function automatic logic exp_bit(input logic [W-1:0] w, input int i, input bit msb);
        if (i >= W) return ^w;
        return msb ? w[W-1-i] : w[i];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; din = 8'hFF; din_valid = 1'b1; din_l = 8'hFF; din_valid_l = 1'b1;
        tick(); tick();
        checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL reset_din_ready got %b exp 0", din_ready); end
        checks++; if (dout !== 1'b0) begin errors++; $display("FAIL reset_dout got %b exp 0", dout); end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dout_valid got %b exp 0", dout_valid); end
        checks++; if (dout_last !== 1'b0) begin errors++; $display("FAIL reset_dout_last got %b exp 0", dout_last); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (dout_l !== 1'b1) begin errors++; $display("FAIL reset_idle_level_lsb got %b exp 1", dout_l); end
        checks++; if (din_ready_l !== 1'b0) begin errors++; $display("FAIL reset_din_ready_lsb got %b exp 0", din_ready_l); end
        din_valid = 1'b0; din_valid_l = 1'b0; reset = 1'b0;
        #1;
        checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL post_reset_din_ready got %b exp 1", din_ready); end
    endtask

    // Sends one word from IDLE on the MSB-first instance and checks the whole frame.
    task automatic send_frame_check(input logic [W-1:0] w, input string tag);
        din = w; din_valid = 1'b1;
        #1;
        checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL %s_ready_idle got %b exp 1", tag, din_ready); end
        tick();
        din_valid = 1'b0; din = W'($urandom);
        for (int i = 0; i < FLEN; i++) begin
            checks++; if (dout !== exp_bit(w, i, 1'b1)) begin errors++; $display("FAIL %s_bit%0d got %b exp %b", tag, i, dout, exp_bit(w, i, 1'b1)); end
            checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL %s_valid%0d got %b exp 1", tag, i, dout_valid); end
            checks++; if (dout_last !== (i == FLEN - 1)) begin errors++; $display("FAIL %s_last%0d got %b exp %b", tag, i, dout_last, (i == FLEN - 1)); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy%0d got %b exp 1", tag, i, busy); end
            checks++; if (din_ready !== (i == FLEN - 1)) begin errors++; $display("FAIL %s_ready%0d got %b exp %b", tag, i, din_ready, (i == FLEN - 1)); end
            tick();
        end
        checks++; if (dout !== 1'b0) begin errors++; $display("FAIL %s_idle_dout got %b exp 0", tag, dout); end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL %s_idle_valid got %b exp 0", tag, dout_valid); end
        checks++; if (dout_last !== 1'b0) begin errors++; $display("FAIL %s_idle_last got %b exp 0", tag, dout_last); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_idle_busy got %b exp 0", tag, busy); end
    endtask

    task automatic test_single_frame();
        send_frame_check(8'hA5, "a5");
        send_frame_check(8'h07, "w07");
        send_frame_check(8'h01, "w01");
    endtask

    task automatic test_lsb_first();
        logic [W-1:0] words [2];
        words[0] = 8'hA5; words[1] = 8'h01;
        for (int k = 0; k < 2; k++) begin
            din_l = words[k]; din_valid_l = 1'b1;
            #1;
            checks++; if (din_ready_l !== 1'b1) begin errors++; $display("FAIL lsb%0d_ready got %b exp 1", k, din_ready_l); end
            tick();
            din_valid_l = 1'b0;
            for (int i = 0; i < FLEN; i++) begin
                checks++; if (dout_l !== exp_bit(words[k], i, 1'b0)) begin errors++; $display("FAIL lsb%0d_bit%0d got %b exp %b", k, i, dout_l, exp_bit(words[k], i, 1'b0)); end
                checks++; if (dout_valid_l !== 1'b1) begin errors++; $display("FAIL lsb%0d_valid%0d got %b exp 1", k, i, dout_valid_l); end
                checks++; if (dout_last_l !== (i == FLEN - 1)) begin errors++; $display("FAIL lsb%0d_last%0d got %b exp %b", k, i, dout_last_l, (i == FLEN - 1)); end
                tick();
            end
            checks++; if (dout_l !== 1'b1) begin errors++; $display("FAIL lsb%0d_idle_dout got %b exp 1", k, dout_l); end
            checks++; if (dout_valid_l !== 1'b0 || busy_l !== 1'b0) begin errors++; $display("FAIL lsb%0d_idle valid/busy got %b%b exp 00", k, dout_valid_l, busy_l); end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] w;
        din = 8'hA5; din_valid = 1'b1;
        #1;
        checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_idle got %b exp 1", din_ready); end
        tick();
        din = 8'h3C;
        for (int f = 0; f < 2; f++) begin
            w = (f == 0) ? 8'hA5 : 8'h3C;
            for (int i = 0; i < FLEN; i++) begin
                if (f == 1 && i == 0) din_valid = 1'b0;
                checks++; if (dout !== exp_bit(w, i, 1'b1)) begin errors++; $display("FAIL b2b_f%0d_bit%0d got %b exp %b", f, i, dout, exp_bit(w, i, 1'b1)); end
                checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL b2b_f%0d_valid%0d got %b exp 1", f, i, dout_valid); end
                checks++; if (din_ready !== (i == FLEN - 1)) begin errors++; $display("FAIL b2b_f%0d_ready%0d got %b exp %b", f, i, din_ready, (i == FLEN - 1)); end
                checks++; if (dout_last !== (i == FLEN - 1)) begin errors++; $display("FAIL b2b_f%0d_last%0d got %b exp %b", f, i, dout_last, (i == FLEN - 1)); end
                tick();
            end
        end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL b2b_end_valid got %b exp 0", dout_valid); end
    endtask

    task automatic test_backpressure();
        int accepts = 0;
        din = 8'hFF; din_valid = 1'b1;
        #1;
        for (int c = 0; c < 2 * FLEN; c++) begin
            if (c >= 1) begin
                checks++; if (dout !== exp_bit(8'hFF, (c - 1) % FLEN, 1'b1) || dout_valid !== 1'b1) begin errors++; $display("FAIL bp_bit_c%0d got %b/%b exp %b/1", c, dout, dout_valid, exp_bit(8'hFF, (c - 1) % FLEN, 1'b1)); end
            end
            checks++; if (din_ready !== (c == 0 || c == FLEN)) begin errors++; $display("FAIL bp_ready_c%0d got %b exp %b", c, din_ready, (c == 0 || c == FLEN)); end
            if (din_valid && din_ready) accepts++;
            tick();
        end
        din_valid = 1'b0;
        checks++; if (accepts !== 2) begin errors++; $display("FAIL bp_accepts got %0d exp 2", accepts); end
        tick();
        checks++; if (dout_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_drain valid/busy got %b%b exp 00", dout_valid, busy); end
    endtask

    task automatic test_reset_mid_frame();
        din = 8'hA5; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        tick(); tick(); tick();
        checks++; if (dout !== exp_bit(8'hA5, 3, 1'b1) || dout_valid !== 1'b1) begin errors++; $display("FAIL midrst_bit4 got %b/%b exp %b/1", dout, dout_valid, exp_bit(8'hA5, 3, 1'b1)); end
        reset = 1'b1; din_valid = 1'b1;
        #1;
        checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got %b exp 0", din_ready); end
        tick();
        din_valid = 1'b0;
        checks++; if (dout !== 1'b0 || dout_valid !== 1'b0 || busy !== 1'b0 || dout_last !== 1'b0) begin errors++; $display("FAIL midrst_idle dout/valid/busy/last got %b%b%b%b exp 0000", dout, dout_valid, busy, dout_last); end
        reset = 1'b0;
        send_frame_check(8'h3C, "after_rst");
    endtask

    // Reference: a queue of bits still owed on the line. The head is the bit
    // that should be visible now; the block may take a word when at most that
    // one bit remains.
    task automatic test_random_stream();
        logic q[$];
        logic [W-1:0] w;
        for (int n = 0; n < 700; n++) begin
            checks++; if (dout_valid !== (q.size() > 0)) begin errors++; $display("FAIL rnd%0d_valid got %b exp %b", n, dout_valid, (q.size() > 0)); end
            checks++; if (busy !== (q.size() > 0)) begin errors++; $display("FAIL rnd%0d_busy got %b exp %b", n, busy, (q.size() > 0)); end
            checks++; if (din_ready !== (q.size() <= 1)) begin errors++; $display("FAIL rnd%0d_ready got %b exp %b", n, din_ready, (q.size() <= 1)); end
            if (q.size() > 0) begin
                checks++; if (dout !== q[0] || dout_last !== (q.size() == 1)) begin errors++; $display("FAIL rnd%0d_bit got %b/%b exp %b/%b", n, dout, dout_last, q[0], (q.size() == 1)); end
            end else begin
                checks++; if (dout !== 1'b0 || dout_last !== 1'b0) begin errors++; $display("FAIL rnd%0d_idle got %b/%b exp 0/0", n, dout, dout_last); end
            end
            w = W'($urandom);
            din = w;
            din_valid = (n < 600) && ($urandom_range(0, 3) != 0);
            if (q.size() > 0) void'(q.pop_front());
            if (din_valid && q.size() == 0) begin
                for (int i = 0; i < FLEN; i++) q.push_back(exp_bit(w, i, 1'b1));
            end
            tick();
        end
        din_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_lsb_first();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_frame();
        test_random_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
